// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: scatters an immediate into an instruction template and numbers the words with imem addresses.
// Optional build macro IMM_ENC_STRICT_EN drops erroneous words instead of presenting them with out_err set.
module imm_encoder #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [31:0]       in_template,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_count
);

    logic              s1_valid_q, s1_valid_d;
    logic [2:0]        s1_sel_q, s1_sel_d;
    logic [31:0]       s1_tmpl_q, s1_tmpl_d;
    logic [31:0]       s1_imm_q, s1_imm_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_instr_q, s2_instr_d;
    logic              s2_err_q, s2_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        s2_show, s2_fire, s2_free, s1_adv, in_hs, out_hs;

    always_comb begin
        enc_instr = s1_tmpl_q;
        enc_err   = 1'b0;
        unique case (s1_sel_q)
            3'b000: begin
                enc_instr = {s1_imm_q[11:0], s1_tmpl_q[19:0]};
                enc_err   = !((s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1));
            end
            3'b001: begin
                enc_instr = {s1_imm_q[11:5], s1_tmpl_q[24:12], s1_imm_q[4:0], s1_tmpl_q[6:0]};
                enc_err   = !((s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1));
            end
            3'b010: begin
                enc_instr = {s1_tmpl_q[31:25], s1_imm_q[4:0], s1_tmpl_q[19:0]};
                enc_err   = (s1_imm_q[31:5] != '0);
            end
            3'b011: begin
                enc_instr = {s1_imm_q[31:12], s1_tmpl_q[11:0]};
                enc_err   = (s1_imm_q[11:0] != '0);
            end
            3'b100: begin
                enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_tmpl_q[24:12],
                             s1_imm_q[4:1], s1_imm_q[11], s1_tmpl_q[6:0]};
                enc_err   = !((s1_imm_q[31:12] == '0) || (s1_imm_q[31:12] == '1)) || s1_imm_q[0];
            end
            3'b101: begin
                enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                             s1_tmpl_q[11:0]};
                enc_err   = !((s1_imm_q[31:20] == '0) || (s1_imm_q[31:20] == '1)) || s1_imm_q[0];
            end
            default: begin
                enc_instr = s1_tmpl_q;
                enc_err   = 1'b1;
            end
        endcase
    end

`ifdef IMM_ENC_STRICT_EN
    // An erroneous word is never shown and retires on its own in one cycle.
    assign s2_show = s2_valid_q && !s2_err_q;
    assign s2_fire = s2_valid_q && (s2_err_q || out_ready);
    assign out_err = 1'b0;
`else
    assign s2_show = s2_valid_q;
    assign s2_fire = s2_valid_q && out_ready;
    assign out_err = s2_err_q;
`endif

    assign s2_free   = !s2_valid_q || s2_fire;
    assign s1_adv    = s1_valid_q && s2_free;
    assign in_ready  = !s1_valid_q || s2_free;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = s2_show && out_ready;
    assign out_valid = s2_show;
    assign out_instr = s2_instr_q;
    assign out_addr  = addr_q;
    assign err_count = err_cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sel_d   = s1_sel_q;
        s1_tmpl_d  = s1_tmpl_q;
        s1_imm_d   = s1_imm_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;

        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_sel_d   = in_sel;
            s1_tmpl_d  = in_template;
            s1_imm_d   = in_imm;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_d = enc_instr;
                s2_err_d   = enc_err;
            end
        end

        if (out_hs)
            addr_d = addr_q + ADDR_W'(4);
        if (s2_fire && s2_err_q && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_tmpl_q  <= '0;
            s1_imm_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            addr_q     <= BASE_ADDR;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sel_q   <= s1_sel_d;
            s1_tmpl_q  <= s1_tmpl_d;
            s1_imm_q   <= s1_imm_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            addr_q     <= addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder; build with IMM_ENC_STRICT_EN defined to exercise the strict variant.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = '0;
    logic [31:0] in_template = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] err_count;

    imm_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_template(in_template), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_addr = '0;
    int unsigned exp_errs = 0;
    bit          rand_rdy = 1'b0;
    bit          stalled  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoder: field placement bit by bit, ranges as signed intervals.
    function automatic void model(input logic [2:0] sel, input logic [31:0] t, input logic [31:0] imm,
                                  output logic [31:0] e, output logic er);
        int signed s;
        s  = imm;
        e  = t;
        er = 1'b0;
        case (sel)
            3'd0: begin e[31:20] = imm[11:0]; er = (s < -2048) || (s > 2047); end
            3'd1: begin e[31:25] = imm[11:5]; e[11:7] = imm[4:0]; er = (s < -2048) || (s > 2047); end
            3'd2: begin e[24:20] = imm[4:0]; er = (imm > 32'd31); end
            3'd3: begin e[31:12] = imm[31:12]; er = (imm % 32'd4096) != 0; end
            3'd4: begin
                e[31] = imm[12]; e[30:25] = imm[10:5]; e[11:8] = imm[4:1]; e[7] = imm[11];
                er = (s < -4096) || (s > 4095) || imm[0];
            end
            3'd5: begin
                e[31] = imm[20]; e[30:21] = imm[10:1]; e[20] = imm[11]; e[19:12] = imm[19:12];
                er = (s < -1048576) || (s > 1048575) || imm[0];
            end
            default: er = 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic [2:0] sel, input logic [31:0] t, input logic [31:0] imm);
        exp_t e;
        model(sel, t, imm, e.instr, e.err);
        if (e.err) exp_errs++;
`ifdef IMM_ENC_STRICT_EN
        if (!e.err) sb.push_back(e);
`else
        sb.push_back(e);
`endif
    endtask

    task automatic send(input logic [2:0] sel, input logic [31:0] t, input logic [31:0] imm);
        int unsigned n = 0;
        bit done = 1'b0;
        in_valid = 1'b1; in_sel = sel; in_template = t; in_imm = imm;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(sel, t, imm);
                done = 1'b1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) tick();
        sb.delete();
        exp_addr = '0;
        exp_errs = 0;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) check_eq("valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check_eq("instr", out_instr, sb[0].instr);
                    check_eq("err", 32'(out_err), 32'(sb[0].err));
                    check_eq("addr", out_addr, exp_addr);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        exp_addr = exp_addr + 32'd4;
                    end
                end
            end
            stalled <= out_valid && !out_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rsel;
        logic [31:0] rimm;
        do_reset();
        rst = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_out_addr", out_addr, 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        tick();

        // Latency: accepted at edge k, visible after edge k+1.
        out_ready = 1'b1;
        in_valid = 1'b1; in_sel = 3'd0; in_template = 32'h00000013; in_imm = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("lat_in_ready", 32'(in_ready), 32'd1);
        push_exp(3'd0, 32'h00000013, 32'hFFFFFFFF);
        tick();
        in_valid = 1'b0;
        check_eq("lat_k", 32'(out_valid), 32'd0);
        tick();
        check_eq("lat_k1", 32'(out_valid), 32'd1);
        check_eq("i_fmt_instr", out_instr, 32'hFFF00013);
        drain();

        // Directed formats and range boundaries.
        send(3'd4, 32'h00000063, 32'h00000010);
        send(3'd4, 32'h00000063, 32'h00000011);
        send(3'd5, 32'h0000006F, 32'h00000800);
        send(3'd3, 32'h00000037, 32'h12345000);
        send(3'd3, 32'h00000037, 32'h12345001);
        send(3'd1, 32'h00002023, 32'hFFFFF800);
        send(3'd1, 32'h00002023, 32'h00000800);
        send(3'd2, 32'h00001013, 32'h0000001F);
        send(3'd2, 32'h00001013, 32'h00000020);
        send(3'd0, 32'h00000013, 32'h000007FF);
        send(3'd4, 32'h00000063, 32'hFFFFF000);
        send(3'd4, 32'h00000063, 32'h00001000);
        send(3'd5, 32'h0000006F, 32'h000FFFFE);
        send(3'd5, 32'h0000006F, 32'hFFF00000);
        send(3'd5, 32'h0000006F, 32'h00100000);
        send(3'd6, 32'hDEADBEEF, 32'h00000000);
        send(3'd7, 32'h12345678, 32'h00000004);
        drain();
        check_eq("dir_err_count", 32'(err_count), exp_errs);

        // Random stream with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rsel = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rimm = 32'($signed($urandom_range(0, 10000)) - 5000);
                1: rimm = $urandom();
                2: rimm = $urandom() & 32'hFFFFF000;
                default: rimm = 32'($signed($urandom_range(0, 32'h300000)) - 32'h180000);
            endcase
            send(rsel, $urandom(), rimm);
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        check_eq("rand_err_count", 32'(err_count), exp_errs);

        // Backpressure: two words buffer, the third is refused until release.
        do_reset();
        out_ready = 1'b0;
        send(3'd0, 32'h00000013, 32'h00000001);
        send(3'd0, 32'h00000013, 32'h00000002);
        in_valid = 1'b1; in_sel = 3'd0; in_template = 32'h00000013; in_imm = 32'h00000003;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(3'd0, 32'h00000013, 32'h00000003);
        drain();
        check_eq("bp_final_addr", out_addr, 32'd12);

        // Error word followed by a good one.
        do_reset();
        send(3'd0, 32'h00000013, 32'h00000800);
        send(3'd0, 32'h00000013, 32'h00000005);
        drain();
        check_eq("strict_err_count", 32'(err_count), 32'd1);

        // Reset with two words buffered.
        out_ready = 1'b0;
        send(3'd3, 32'h00000037, 32'h00001000);
        send(3'd0, 32'h00000013, 32'h00000800);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_out_addr", out_addr, 32'd0);
        check_eq("mid_rst_err_count", 32'(err_count), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        exp_addr = '0;
        exp_errs = 0;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder: the inverse of the core's immediate sign extender. It takes an instruction template, a format select and a 32-bit immediate value. It checks that the immediate is representable in that format, scatters its bits into the RISC-V instruction fields, and emits the finished word with a sequential instruction-memory address. It sits in the program-load / self-test path, feeding instruction memory from a host or test sequencer.

## Interface
Parameters:
- ADDR_W, 32, width of the output address counter
- BASE_ADDR, 0, address of the first emitted word

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input word offered
- in_ready  out  1  encoder accepts input this cycle
- in_sel  in  3  format select: 000 I, 001 S, 010 shamt, 011 U, 100 B, 101 J, 110/111 illegal
- in_template  in  32  opcode/funct/register bits; immediate-field bits are ignored
- in_imm  in  32  immediate value, two's complement, byte offset for B/J
- out_valid  out  1  encoded word present
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  imem byte address of out_instr
- out_err  out  1  immediate out of range / misaligned / illegal select
- err_count  out  16  saturating count of erroneous words

## Operation
- Two register stages:
  - S1 captures in_sel, in_template and in_imm on an input handshake.
  - S2 holds the encoded word and error flag.
- Field mask per format: template bits in the immediate field are cleared, then the immediate bits are ORed in. All other template bits pass unchanged.
- Encodings and range checks:
  - I: [31:20]=imm[11:0]. Error unless imm[31:11] are all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range check as I.
  - shamt: [24:20]=imm[4:0]. Error unless imm[31:5]==0.
  - U: [31:12]=imm[31:12]. Error unless imm[11:0]==0.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Error unless imm[31:12] are all equal and imm[0]==0.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Error unless imm[31:20] are all equal and imm[0]==0.
  - 110/111: out_instr=in_template unchanged, error set.
- On error the word is still emitted, carrying the truncated field bits, with out_err=1.
- out_addr:
  - Starts at BASE_ADDR.
  - Increments by 4 on every output handshake (out_valid && out_ready).
  - Wraps modulo 2^ADDR_W.
- err_count increments on each output handshake with out_err=1 and saturates at 16'hFFFF.

## Timing
- Reset values: in_ready=1 (combinationally derived from empty stages), out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_count=0.
- Reset mid-operation flushes both stages; words in flight are discarded and not counted.
- Latency: an input accepted at edge k gives out_valid=1 after edge k+1, provided S2 was free.
- Throughput: one word per cycle while out_ready=1.
- Stage advance rules:
  - S2 loads when S2 is empty or firing.
  - S1 loads when S1 is empty or advancing.
  - in_ready = !S1_valid || S1 advances. This is a combinational path from out_ready; that path is permitted.
- While out_valid && !out_ready, out_instr, out_addr and out_err are held stable. At most 2 words are buffered, after which in_ready=0.
- A simultaneous input and output handshake in the same cycle is legal, and occupancy is unchanged.
- out_valid never drops without a handshake, except on rst.

## Configuration
- IMM_ENC_STRICT_EN:
  - Defined: an erroneous word in S2 is dropped instead of presented. out_valid stays 0 for it, it retires in one cycle regardless of out_ready, out_addr does not advance, and err_count still increments. out_err is tied 0.
  - Undefined: erroneous words are emitted with out_err=1 as described above.

## Test plan
- I format: template 0x00000013, sel 000, imm 0xFFFFFFFF → out_instr 0xFFF00013, out_err 0, out_addr 0x0, out_valid 2 cycles after the input handshake.
- B/J formats:
  - sel 100, template 0x00000063, imm 0x10 → 0x00000863.
  - sel 100, imm 0x11 → out_err 1.
  - sel 101, template 0x0000006F, imm 0x800 → 0x0010006F.
- U format: template 0x00000037, imm 0x12345000 → 0x12345037, err 0. The same template with imm 0x12345001 → 0x12345037, err 1, err_count 1 (non-strict build).
- Backpressure: hold out_ready=0 while offering 3 words → exactly 2 accepted, then in_ready=0. Release out_ready → words emitted in order at addresses 0x0, 0x4, 0x8.
- Strict build (IMM_ENC_STRICT_EN): stream I(imm 0x800, err), I(imm 5) → only the second word is emitted, at out_addr 0x0, and err_count is 1.
- Reset mid-stream: assert rst with 2 words buffered → next cycle out_valid=0, out_addr=BASE_ADDR, err_count=0, in_ready=1.
